// File: rtl/udma_hyper_pkg.sv
// Shared types for the HyperBus transaction queue.
package udma_hyper_pkg;

  typedef enum logic {TQ_IDLE, TQ_ACTIVE} tq_state_e;

endpackage

// File: rtl/udma_hyper_cmd_fifo.sv
// Synchronous show-ahead FIFO: head entry is read straight from registered storage.
module udma_hyper_cmd_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic [DATA_W-1:0]            data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Push gating uses the pre-cycle full flag, so push+pop while full only pops.
    push     = push_i & ~full_o;
    pop      = pop_i & ~empty_o;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/udma_hyper_trans_queue.sv
// In-order descriptor queue between the HyperBus register interface and the transaction engine.
module udma_hyper_trans_queue
  import udma_hyper_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        trans_valid_i,
  output logic                        trans_ready_o,
  input  logic                        flush_i,
  input  logic [31:0]                 cfg_hyper_addr_i,
  input  logic [15:0]                 cfg_hyper_intreg_i,
  input  logic                        cfg_rw_hyper_i,
  input  logic                        cfg_addr_space_i,
  input  logic                        cfg_burst_type_i,
  input  logic [L2_AWIDTH_NOAL-1:0]   cfg_l2_addr_i,
  input  logic [TRANS_SIZE-1:0]       cfg_size_i,
  input  logic                        cfg_twd_ext_act_i,
  input  logic                        cfg_twd_l2_act_i,
  input  logic [TRANS_SIZE-1:0]       cfg_twd_ext_count_i,
  input  logic [TRANS_SIZE-1:0]       cfg_twd_ext_stride_i,
  input  logic [TRANS_SIZE-1:0]       cfg_twd_l2_count_i,
  input  logic [TRANS_SIZE-1:0]       cfg_twd_l2_stride_i,
  output logic [31:0]                 head_hyper_addr_o,
  output logic [15:0]                 head_hyper_intreg_o,
  output logic                        head_rw_hyper_o,
  output logic                        head_addr_space_o,
  output logic                        head_burst_type_o,
  output logic [L2_AWIDTH_NOAL-1:0]   head_l2_addr_o,
  output logic [TRANS_SIZE-1:0]       head_size_o,
  output logic                        head_twd_ext_act_o,
  output logic                        head_twd_l2_act_o,
  output logic [TRANS_SIZE-1:0]       head_twd_ext_count_o,
  output logic [TRANS_SIZE-1:0]       head_twd_ext_stride_o,
  output logic [TRANS_SIZE-1:0]       head_twd_l2_count_o,
  output logic [TRANS_SIZE-1:0]       head_twd_l2_stride_o,
  output logic                        head_valid_o,
  input  logic                        head_ready_i,
  input  logic                        trans_done_i,
  output logic [$clog2(DEPTH+1)-1:0]  nb_trans_waiting_o,
  output logic                        busy_o
);

  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned DATA_W = 54 + 2 + 5*TRANS_SIZE + L2_AWIDTH_NOAL;

  tq_state_e          state_q, state_d;
  logic [DATA_W-1:0]  fifo_din, fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [2:0]         unused_rsvd;

  // Three reserved bits pad the CA field group to its fixed 54-bit slot.
  assign fifo_din = {cfg_hyper_addr_i, cfg_hyper_intreg_i, 3'b000,
                     cfg_rw_hyper_i, cfg_addr_space_i, cfg_burst_type_i,
                     cfg_twd_ext_act_i, cfg_twd_l2_act_i, cfg_l2_addr_i, cfg_size_i,
                     cfg_twd_ext_count_i, cfg_twd_ext_stride_i,
                     cfg_twd_l2_count_i, cfg_twd_l2_stride_i};

  assign {head_hyper_addr_o, head_hyper_intreg_o, unused_rsvd,
          head_rw_hyper_o, head_addr_space_o, head_burst_type_o,
          head_twd_ext_act_o, head_twd_l2_act_o, head_l2_addr_o, head_size_o,
          head_twd_ext_count_o, head_twd_ext_stride_o,
          head_twd_l2_count_o, head_twd_l2_stride_o} = fifo_dout;

  assign trans_ready_o      = ~fifo_full;
  assign push               = trans_valid_i & trans_ready_o;
  // Flush masks the head so the engine never sees a handshake the FIFO ignores.
  assign head_valid_o       = ~fifo_empty & ~flush_i &
                              ((state_q == TQ_IDLE) | trans_done_i);
  assign pop                = head_valid_o & head_ready_i;
  assign busy_o             = ~fifo_empty | (state_q == TQ_ACTIVE);
  assign nb_trans_waiting_o = fifo_count;

  udma_hyper_cmd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) i_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  (fifo_din),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      TQ_IDLE:   if (pop) state_d = TQ_ACTIVE;
      TQ_ACTIVE: if (trans_done_i && !pop) state_d = TQ_IDLE;
      default:   state_d = TQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= TQ_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_udma_hyper_trans_queue.sv
// Randomized bench for udma_hyper_trans_queue against a queue-based reference model.
module tb_udma_hyper_trans_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] intreg;
    logic        rw;
    logic        space;
    logic        burst;
    logic        ext_act;
    logic        l2_act;
    logic [11:0] l2_addr;
    logic [15:0] size;
    logic [15:0] ext_cnt;
    logic [15:0] ext_str;
    logic [15:0] l2_cnt;
    logic [15:0] l2_str;
  } desc_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trans_valid_i, flush_i, head_ready_i, trans_done_i;
  desc_t       in_d;
  desc_t       head_bus;
  logic        trans_ready_o, head_valid_o, busy_o;
  logic [2:0]  nb_trans_waiting_o;
  logic [31:0] head_hyper_addr_o;
  logic [15:0] head_hyper_intreg_o;
  logic        head_rw_hyper_o, head_addr_space_o, head_burst_type_o;
  logic        head_twd_ext_act_o, head_twd_l2_act_o;
  logic [11:0] head_l2_addr_o;
  logic [15:0] head_size_o, head_twd_ext_count_o, head_twd_ext_stride_o;
  logic [15:0] head_twd_l2_count_o, head_twd_l2_stride_o;

  int    n_tests = 0;
  int    n_fail  = 0;
  desc_t q[$];
  bit    active;

  always #5 clk_i = ~clk_i;

  assign head_bus = {head_hyper_addr_o, head_hyper_intreg_o, head_rw_hyper_o,
                     head_addr_space_o, head_burst_type_o, head_twd_ext_act_o,
                     head_twd_l2_act_o, head_l2_addr_o, head_size_o,
                     head_twd_ext_count_o, head_twd_ext_stride_o,
                     head_twd_l2_count_o, head_twd_l2_stride_o};

  udma_hyper_trans_queue #(
    .L2_AWIDTH_NOAL (12),
    .TRANS_SIZE     (16),
    .DEPTH          (DEPTH)
  ) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .trans_valid_i         (trans_valid_i),
    .trans_ready_o         (trans_ready_o),
    .flush_i               (flush_i),
    .cfg_hyper_addr_i      (in_d.addr),
    .cfg_hyper_intreg_i    (in_d.intreg),
    .cfg_rw_hyper_i        (in_d.rw),
    .cfg_addr_space_i      (in_d.space),
    .cfg_burst_type_i      (in_d.burst),
    .cfg_l2_addr_i         (in_d.l2_addr),
    .cfg_size_i            (in_d.size),
    .cfg_twd_ext_act_i     (in_d.ext_act),
    .cfg_twd_l2_act_i      (in_d.l2_act),
    .cfg_twd_ext_count_i   (in_d.ext_cnt),
    .cfg_twd_ext_stride_i  (in_d.ext_str),
    .cfg_twd_l2_count_i    (in_d.l2_cnt),
    .cfg_twd_l2_stride_i   (in_d.l2_str),
    .head_hyper_addr_o     (head_hyper_addr_o),
    .head_hyper_intreg_o   (head_hyper_intreg_o),
    .head_rw_hyper_o       (head_rw_hyper_o),
    .head_addr_space_o     (head_addr_space_o),
    .head_burst_type_o     (head_burst_type_o),
    .head_l2_addr_o        (head_l2_addr_o),
    .head_size_o           (head_size_o),
    .head_twd_ext_act_o    (head_twd_ext_act_o),
    .head_twd_l2_act_o     (head_twd_l2_act_o),
    .head_twd_ext_count_o  (head_twd_ext_count_o),
    .head_twd_ext_stride_o (head_twd_ext_stride_o),
    .head_twd_l2_count_o   (head_twd_l2_count_o),
    .head_twd_l2_stride_o  (head_twd_l2_stride_o),
    .head_valid_o          (head_valid_o),
    .head_ready_i          (head_ready_i),
    .trans_done_i          (trans_done_i),
    .nb_trans_waiting_o    (nb_trans_waiting_o),
    .busy_o                (busy_o)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_desc();
    logic [159:0] r;
    r    = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_d = r[144:0];
  endtask

  // Check outputs mid-cycle against the model, then advance the model by one clock.
  task automatic cycle();
    bit exp_hv, pop, push;
    @(negedge clk_i);
    exp_hv = (q.size() != 0) && (!active || trans_done_i) && !flush_i;
    check("ready", 160'(trans_ready_o), 160'(q.size() != DEPTH));
    check("hvalid", 160'(head_valid_o), 160'(exp_hv));
    check("busy", 160'(busy_o), 160'((q.size() != 0) || active));
    check("count", 160'(nb_trans_waiting_o), 160'(q.size()));
    if (q.size() != 0) check("head", 160'(head_bus), 160'(q[0]));
    pop  = exp_hv && head_ready_i;
    push = trans_valid_i && (q.size() != DEPTH);
    if (rst_i) begin
      q.delete();
      active = 1'b0;
    end else begin
      if (flush_i) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(in_d);
      end
      if (!active && pop) active = 1'b1;
      else if (active && trans_done_i && !pop) active = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; trans_valid_i = 1'b0; flush_i = 1'b0;
    head_ready_i = 1'b0; trans_done_i = 1'b0; in_d = '0;
    active = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst_ready", 160'(trans_ready_o), 160'(1));
    check("rst_hvalid", 160'(head_valid_o), 160'(0));
    check("rst_busy", 160'(busy_o), 160'(0));
    check("rst_count", 160'(nb_trans_waiting_o), 160'(0));
    check("rst_head", 160'(head_bus), 160'(0));
    @(posedge clk_i);
    #1;

    // Single transaction
    rand_desc();
    in_d.addr = 32'h0000_1000; in_d.size = 16'h0040; in_d.rw = 1'b1;
    trans_valid_i = 1'b1; head_ready_i = 1'b1;
    cycle();
    trans_valid_i = 1'b0;
    repeat (4) cycle();
    trans_done_i = 1'b1; cycle();
    trans_done_i = 1'b0; cycle();

    // Overfill with engine stalled, then drain in order
    head_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rand_desc();
      in_d.addr = 32'(i);
      trans_valid_i = 1'b1;
      cycle();
    end
    trans_valid_i = 1'b0;
    head_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      trans_done_i = (i % 2 == 1);
      cycle();
    end
    trans_done_i = 1'b1; head_ready_i = 1'b0; cycle();
    trans_done_i = 1'b0; cycle();

    // Idle engine, count 2, simultaneous push+pop
    for (int i = 0; i < 2; i++) begin
      rand_desc(); trans_valid_i = 1'b1; cycle();
    end
    rand_desc(); head_ready_i = 1'b1; cycle();
    trans_valid_i = 1'b0; head_ready_i = 1'b0; cycle();

    // Back-to-back pops on trans_done_i
    head_ready_i = 1'b1; trans_done_i = 1'b1; cycle();
    cycle();
    trans_done_i = 1'b0; head_ready_i = 1'b0; cycle();

    // Flush while active, then reset mid-transfer
    head_ready_i = 1'b0; trans_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_desc(); cycle();
    end
    trans_valid_i = 1'b0;
    flush_i = 1'b1; cycle();
    flush_i = 1'b0; repeat (3) cycle();
    trans_done_i = 1'b1; cycle();
    trans_done_i = 1'b0; cycle();
    for (int i = 0; i < 2; i++) begin
      rand_desc(); trans_valid_i = 1'b1; cycle();
    end
    trans_valid_i = 1'b0; head_ready_i = 1'b1; cycle();
    head_ready_i = 1'b0; rst_i = 1'b1; cycle();
    rst_i = 1'b0; cycle();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_desc();
      trans_valid_i = ($urandom_range(0, 99) < 50);
      head_ready_i  = ($urandom_range(0, 99) < 60);
      trans_done_i  = ($urandom_range(0, 99) < 25);
      flush_i       = ($urandom_range(0, 99) < 3);
      rst_i         = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
